main_memory: RTL and testbench
==============================

# main_memory

Fixed-latency backing memory that serves the line-granular read and write request ports of a direct-mapped cache. It sits directly downstream of the cache. It accepts one transaction at a time and services a pending write before a pending read, so a dirty-line eviction lands before the refill of the same index. Each transaction is completed with a one-cycle acknowledge pulse after a programmable latency.

## Interface

Parameters:
- `WIDTH`, default `` `MEMORY_WIDTH ``: bits per line; must match the cache line width; power of two, ≥32.
- `LINES`, default 4096: number of lines stored; power of two.
- `LATENCY`, default 10: cycles from acceptance to acknowledge; ≥1.
- `INIT_FILE`, default "": hex file loaded into the array at elaboration (`$readmemh`) when non-empty.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `write_req`  in  1  write request, level; held until `write_ack`.
- `write_addr`  in  32  byte address of the line to write.
- `write_data`  in  WIDTH  line data to write.
- `write_ack`  out  1  one-cycle pulse: write committed.
- `read_req`  in  1  read request, level; held until `read_ack`.
- `read_addr`  in  32  byte address of the line to read.
- `read_data`  out  WIDTH  line read; valid from the `read_ack` cycle; held until the next read completes.
- `read_ack`  out  1  one-cycle pulse: `read_data` valid.
- `busy`  out  1  high while a transaction is in flight, including the ack cycle.

## Operation

- Line index = `addr[LB+WB-1:WB]`, where WB = log2(WIDTH)-3 and LB = log2(LINES).
  - Offset bits and bits above the index are ignored, so addresses alias modulo LINES lines.
- States:
  - IDLE:
    - `write_req`=1 → latch write address and data, go to WRITE.
    - Otherwise `read_req`=1 → latch read address, go to READ.
    - Otherwise stay in IDLE.
    - Write always wins a simultaneous request.
  - WRITE / READ:
    - The down-counter is loaded with LATENCY-1 on entry and decrements each cycle.
    - At count 0, the transaction completes on the next edge and the block enters ACK.
  - ACK:
    - Exactly one cycle.
    - The matching ack is high.
    - Always returns to IDLE.
- Write completion: `array[index] <= latched data` at the edge entering ACK.
- Read completion: `read_data <= array[index]` at the same edge.
  - Reads observe all earlier completed writes, including a write to the same line immediately before.
- Latched address and data are used for the whole transaction. Input changes after acceptance are ignored.
- A requester dropping its req before the ack does not abort the transaction; the ack still pulses.
- The requester must deassert req no later than the end of the ack cycle. IDLE samples req on the edge after ACK.
- Counter width is clog2(LATENCY+1). It never wraps: it reloads only on entry to WRITE/READ.

## Timing

- Reset values:
  - state IDLE.
  - `write_ack`, `read_ack`, `busy` = 0.
  - `read_data` = 0.
  - Counter and latches = 0.
  - Array contents are not cleared.
- Request sampled high at edge E0 (in IDLE) → ack high during cycle after edge E0+LATENCY → IDLE after edge E0+LATENCY+1.
  - Earliest next acceptance is edge E0+LATENCY+1.
- `busy` rises after E0 and falls after E0+LATENCY+1.
- Simultaneous write+read at E0:
  - `write_ack` follows edge E0+LATENCY.
  - Read is accepted at E0+LATENCY+1.
  - `read_ack` follows edge E0+2·LATENCY+1.
- Reset mid-transaction:
  - Aborts the transaction.
  - No array write occurs.
  - No ack is issued.
  - Outputs return to reset values at that edge.
- Reset during the ACK cycle: the array update has already happened at the entering edge and is retained.

## Test plan

- **Single read**, LATENCY=10, array preloaded with line 5 = 0xA5A5…:
  - `read_req`=1, `read_addr`=5·(WIDTH/8) at edge 0.
  - `read_ack` is high for exactly one cycle, after edge 10.
  - `read_data` = 0xA5A5… and is held afterwards.
  - `busy` is high for cycles 1–11.
- **Write then read same line**:
  - `write_req` and `read_req` rise together, both addressing line 3, `write_data` = 0x1234….
  - `write_ack` follows edge 10; `read_ack` follows edge 21.
  - `read_data` = 0x1234….
- **Address aliasing and offset**:
  - Write line 0 via an address with offset bits set.
  - Read via addr + LINES·(WIDTH/8).
  - Returns the written data.
- **Input change after acceptance**:
  - Change `write_addr` and `write_data` one cycle after acceptance.
  - The originally latched line and data are the ones stored.
- **Reset mid-transaction**:
  - Assert `reset` for one cycle at edge 5 of a write to line 7.
  - No `write_ack`; line 7 is unchanged.
  - All outputs read 0.
  - A new read accepted after reset completes normally 10 cycles later.
- **LATENCY=1 back-to-back reads**:
  - Requester drops req combinationally on ack and re-raises it the next cycle.
  - Accepts occur every 3 edges.
  - Acks pulse one cycle each with the correct data.

Source files
------------

// File: rtl/main_memory.sv
// main_memory: fixed-latency, line-granular backing store for a direct-mapped cache.
//
// One transaction is in flight at a time. A pending write is served before a
// pending read, so a dirty-line eviction lands before the refill of the same
// index. Each transaction ends with a one-cycle acknowledge pulse LATENCY
// cycles after it is accepted.
//
// Parameters:
//   WIDTH     bits per line (power of two, >= 32)
//   LINES     number of lines (power of two)
//   LATENCY   cycles from acceptance to acknowledge (>= 1)
//   INIT_FILE optional hex image loaded into the array at elaboration
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   write_req/addr/data  level write request, byte address, line data
//   write_ack          one-cycle pulse: write committed
//   read_req/addr      level read request, byte address
//   read_data          line read; valid from read_ack, held until next read
//   read_ack           one-cycle pulse: read_data valid
//   busy               high while a transaction is in flight, incl. ack cycle

`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module main_memory #(
  parameter int unsigned WIDTH     = `MEMORY_WIDTH,
  parameter int unsigned LINES     = 4096,
  parameter int unsigned LATENCY   = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_req,
  input  logic [31:0]      write_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             write_ack,
  input  logic             read_req,
  input  logic [31:0]      read_addr,
  output logic [WIDTH-1:0] read_data,
  output logic             read_ack,
  output logic             busy
);

  localparam int unsigned WB   = $clog2(WIDTH) - 3;
  localparam int unsigned LB   = $clog2(LINES);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StAck   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LB-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic            is_wr_q, is_wr_d;
  logic [WIDTH-1:0] read_data_q;
  logic            mem_we;
  logic            mem_re;
  logic            wr_ok;
  logic            rd_ok;

  logic [WIDTH-1:0] mem_q [LINES];

  logic [LB-1:0] widx;
  logic [LB-1:0] ridx;
  logic          unused_addr;

  assign widx = write_addr[LB+WB-1:WB];
  assign ridx = read_addr[LB+WB-1:WB];
  // Offset bits and bits above the index are deliberately ignored (aliasing).
  assign unused_addr = ^{write_addr, read_addr};

  // The ACK cycle arbitrates like IDLE so a request queued behind the acked
  // one is taken on the edge leaving ACK. The port being acked is masked: its
  // requester may still hold req during its own ack cycle.
  always_comb begin
    wr_ok = write_req;
    rd_ok = read_req;
    if (state_q == StAck) begin
      wr_ok = write_req && !is_wr_q;
      rd_ok = read_req && is_wr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      StIdle, StAck: begin
        if (wr_ok) begin
          state_d = StWrite;
          cnt_d   = CntW'(LATENCY - 1);
          addr_d  = widx;
          wdata_d = write_data;
          is_wr_d = 1'b1;
        end else if (rd_ok) begin
          state_d = StRead;
          cnt_d   = CntW'(LATENCY - 1);
          addr_d  = ridx;
          is_wr_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StWrite, StRead: begin
        if (cnt_q == '0) begin
          state_d = StAck;
          mem_we  = (state_q == StWrite);
          mem_re  = (state_q == StRead);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Array is never cleared; reset only suppresses an in-flight commit.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else if (mem_re) begin
      read_data_q <= mem_q[addr_q];
    end
  end

  assign read_data = read_data_q;
  assign write_ack = (state_q == StAck) && is_wr_q;
  assign read_ack  = (state_q == StAck) && !is_wr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: stimulus pushes expected ack cycles and
// read data into queues; a monitor pops and compares on every ack.

module tb_main_memory;

  localparam int W  = 64;
  localparam int NL = 16;
  localparam int L0 = 10;
  localparam int LB = 8;  // bytes per line

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        write_req = 1'b0, read_req = 1'b0;
  logic [31:0] write_addr = '0, read_addr = '0;
  logic [63:0] write_data = '0;
  logic        write_ack, read_ack, busy;
  logic [63:0] read_data;

  logic        w1_req = 1'b0, r1_req = 1'b0;
  logic [31:0] w1_addr = '0, r1_addr = '0;
  logic [63:0] w1_data = '0;
  logic        w1_ack, r1_ack, busy1;
  logic [63:0] r1_data;

  exp_t rd_q[$];
  int   wr_q[$];
  exp_t rd1_q[$];
  int   wr1_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  main_memory #(.WIDTH(W), .LINES(NL), .LATENCY(L0), .INIT_FILE("")) u_dut (
    .clk        (clk),
    .reset      (reset),
    .write_req  (write_req),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_ack  (write_ack),
    .read_req   (read_req),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_ack   (read_ack),
    .busy       (busy)
  );

  main_memory #(.WIDTH(W), .LINES(NL), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .write_req  (w1_req),
    .write_addr (w1_addr),
    .write_data (w1_data),
    .write_ack  (w1_ack),
    .read_req   (r1_req),
    .read_addr  (r1_addr),
    .read_data  (r1_data),
    .read_ack   (r1_ack),
    .busy       (busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (write_ack) begin
      if (wr_q.size() == 0) fail_now("wack0_unexpected");
      else begin
        c = wr_q.pop_front();
        check("wack0_cycle", 64'(cyc), 64'(c));
      end
    end
    if (read_ack) begin
      if (rd_q.size() == 0) fail_now("rack0_unexpected");
      else begin
        e = rd_q.pop_front();
        check("rack0_cycle", 64'(cyc), 64'(e.cyc));
        check("rack0_data", read_data, e.data);
      end
    end
    if (w1_ack) begin
      if (wr1_q.size() == 0) fail_now("wack1_unexpected");
      else begin
        c = wr1_q.pop_front();
        check("wack1_cycle", 64'(cyc), 64'(c));
      end
    end
    if (r1_ack) begin
      if (rd1_q.size() == 0) fail_now("rack1_unexpected");
      else begin
        e = rd1_q.pop_front();
        check("rack1_cycle", 64'(cyc), 64'(e.cyc));
        check("rack1_data", r1_data, e.data);
      end
    end
  end

  task automatic wait_wack0();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (write_ack) return;
    end
    fail_now("wack0_timeout");
  endtask

  task automatic wait_rack0();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_ack) return;
    end
    fail_now("rack0_timeout");
  endtask

  task automatic wr0(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    write_req  = 1'b1;
    write_addr = a;
    write_data = d;
    wr_q.push_back(cyc + 1 + L0);
    wait_wack0();
    write_req = 1'b0;
  endtask

  task automatic rd0(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    read_req  = 1'b1;
    read_addr = a;
    rd_q.push_back('{cyc: cyc + 1 + L0, data: d});
    wait_rack0();
    read_req = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    w1_req  = 1'b1;
    w1_addr = a;
    w1_data = d;
    wr1_q.push_back(cyc + 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w1_ack) break;
    end
    w1_req = 1'b0;
  endtask

  localparam logic [63:0] DA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] D12 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] D77 = 64'h7777_0000_7777_0007;
  localparam logic [63:0] D99 = 64'h9999_1111_9999_0009;
  localparam logic [63:0] DAL = 64'h0BAD_CAFE_0000_00A1;
  localparam logic [63:0] DIN = 64'h2222_3333_4444_5555;

  initial begin
    int n;
    int base;
    int k;

    repeat (3) @(negedge clk);
    check("rst_write_ack", 64'(write_ack), 64'd0);
    check("rst_read_ack", 64'(read_ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_read_data", read_data, 64'd0);
    reset = 1'b0;

    // Preload through the write port.
    wr0(5 * LB, DA5);
    wr0(7 * LB, D77);
    wr0(9 * LB, D99);

    // Single read with busy window and hold check.
    @(negedge clk);
    read_req  = 1'b1;
    read_addr = 5 * LB;
    rd_q.push_back('{cyc: cyc + 1 + L0, data: DA5});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (read_ack) read_req = 1'b0;
    end
    check("busy_cycles", 64'(n), 64'(L0 + 1));
    check("read_data_held", read_data, DA5);

    // Simultaneous write+read of line 3: write first, read sees it.
    @(negedge clk);
    write_req  = 1'b1;
    write_addr = 3 * LB;
    write_data = D12;
    read_req   = 1'b1;
    read_addr  = 3 * LB;
    wr_q.push_back(cyc + 1 + L0);
    rd_q.push_back('{cyc: cyc + 1 + 2 * L0 + 1, data: D12});
    wait_wack0();
    write_req = 1'b0;
    wait_rack0();
    read_req = 1'b0;

    // Aliasing: offset bits on write, +LINES lines on read.
    wr0(32'd5, DAL);
    rd0(32'(NL * LB), DAL);

    // Inputs changed one cycle after acceptance are ignored.
    @(negedge clk);
    write_req  = 1'b1;
    write_addr = 2 * LB;
    write_data = DIN;
    wr_q.push_back(cyc + 1 + L0);
    @(negedge clk);
    write_addr = 9 * LB;
    write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_wack0();
    write_req = 1'b0;
    rd0(2 * LB, DIN);
    rd0(9 * LB, D99);

    // Reset at edge 5 of a write to line 7.
    @(negedge clk);
    write_req  = 1'b1;
    write_addr = 7 * LB;
    write_data = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_write_ack", 64'(write_ack), 64'd0);
    check("midrst_read_ack", 64'(read_ack), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_read_data", read_data, 64'd0);
    reset     = 1'b0;
    write_req = 1'b0;
    repeat (15) @(negedge clk);
    check("postrst_busy", 64'(busy), 64'd0);
    rd0(7 * LB, D77);

    // LATENCY=1 back-to-back reads, accepts every 3 edges.
    wr1(1 * LB, 64'h0101_0101_0101_0101);
    wr1(2 * LB, 64'h0202_0202_0202_0202);
    wr1(3 * LB, 64'h0303_0303_0303_0303);
    @(negedge clk);
    r1_req  = 1'b1;
    r1_addr = 1 * LB;
    base    = cyc + 1;
    rd1_q.push_back('{cyc: base + 1, data: 64'h0101_0101_0101_0101});
    rd1_q.push_back('{cyc: base + 4, data: 64'h0202_0202_0202_0202});
    rd1_q.push_back('{cyc: base + 7, data: 64'h0303_0303_0303_0303});
    k = 0;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (r1_ack) begin
        r1_req = 1'b0;
        k++;
        if (k < 3) begin
          @(negedge clk);
          r1_req  = 1'b1;
          r1_addr = 32'((k + 1) * LB);
        end
      end
    end
    if (k < 3) fail_now("rack1_timeout");
    repeat (5) @(negedge clk);

    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("rd1_q_empty", 64'(rd1_q.size()), 64'd0);
    check("wr1_q_empty", 64'(wr1_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
